fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 26 ++
 rtl/fetch_sequencer_if.sv | 46 ++++
 rtl/fetch_sequencer_next_pc.sv | 81 ++++++++
 rtl/fetch_sequencer.sv | 61 ++++++
 tb/tb_fetch_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage types: bus widths, reset/depth defaults and the fetch state encoding.
// Pure declarations; no logic, no latency.
package fetch_sequencer_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  localparam addr_t       RESET_PC_DEF   = 16'h0000;
  localparam int unsigned IMEM_DEPTH_DEF = 256;

  typedef enum logic [2:0] {
    ST_PRIME  = 3'd0,
    ST_RUN    = 3'd1,
    ST_HOLD   = 3'd2,
    ST_BUBBLE = 3'd3,
    ST_FAULT  = 3'd4
  } fetch_state_e;

  function automatic logic addr_in_range(input addr_t a, input int unsigned depth);
    return 32'(a) < depth;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle: decode-side controls, instruction-memory port and fetch output.
// master = fetch sequencer, slave = surrounding pipeline / memory.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic   stall;
  logic   kill;
  logic   redirect_valid;
  addr_t  redirect_target;
  addr_t  imem_addr;
  logic   imem_stall;
  instr_t imem_instruction;
  instr_t if_instruction;
  addr_t  if_pc;
  logic   if_valid;
  logic   fetch_fault;

  modport master (
    input  stall,
    input  kill,
    input  redirect_valid,
    input  redirect_target,
    input  imem_instruction,
    output imem_addr,
    output imem_stall,
    output if_instruction,
    output if_pc,
    output if_valid,
    output fetch_fault
  );

  modport slave (
    output stall,
    output kill,
    output redirect_valid,
    output redirect_target,
    output imem_instruction,
    input  imem_addr,
    input  imem_stall,
    input  if_instruction,
    input  if_pc,
    input  if_valid,
    input  fetch_fault
  );

endinterface

// File: rtl/fetch_sequencer_next_pc.sv
// Fetch FSM and next-PC / next-output selection; purely combinational apart from the state register.
// Priority per edge: redirect > fault > stall > out-of-range > prime > kill/normal.
module fetch_next_pc
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_stall,
  input  logic  i_kill,
  input  logic  i_redirect_valid,
  input  addr_t i_redirect_target,
  input  addr_t i_pc,
  input  addr_t i_pc_q,
  input  logic  i_v_q,
  output addr_t o_pc_nxt,
  output addr_t o_pc_q_nxt,
  output logic  o_v_nxt,
  output logic  o_fault
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic         w_pc_ok;
  logic         w_tgt_ok;

  assign w_pc_ok  = addr_in_range(i_pc, IMEM_DEPTH);
  assign w_tgt_ok = addr_in_range(i_redirect_target, IMEM_DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An out-of-range redirect from FAULT stays in FAULT so fetch_fault never blips low.
  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect_valid) begin
      w_state_nxt = (r_state == ST_FAULT && !w_tgt_ok) ? ST_FAULT : ST_BUBBLE;
    end else if (r_state == ST_FAULT) begin
      w_state_nxt = ST_FAULT;
    end else if (i_stall) begin
      w_state_nxt = (r_state == ST_PRIME) ? ST_PRIME : ST_HOLD;
    end else if (!w_pc_ok) begin
      w_state_nxt = ST_FAULT;
    end else begin
      w_state_nxt = ST_RUN;
    end
  end

  // PRIME spends one edge loading RESET_PC into the memory; the data it returns is the first real word.
  always_comb begin
    o_pc_nxt   = i_pc;
    o_pc_q_nxt = i_pc_q;
    o_v_nxt    = i_v_q;
    o_fault    = (r_state == ST_FAULT);
    if (i_redirect_valid) begin
      o_pc_nxt   = i_redirect_target;
      o_pc_q_nxt = i_pc;
      o_v_nxt    = 1'b0;
    end else if (r_state == ST_FAULT) begin
      o_v_nxt = 1'b0;
    end else if (i_stall) begin
      o_v_nxt = i_v_q;
    end else if (!w_pc_ok) begin
      o_v_nxt = 1'b0;
    end else if (r_state == ST_PRIME) begin
      o_pc_q_nxt = i_pc;
      o_v_nxt    = 1'b0;
    end else begin
      o_pc_nxt   = i_pc + 16'd1;
      o_pc_q_nxt = i_pc;
      o_v_nxt    = ~i_kill;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: pc / pc_q / v_q registers around the fetch_next_pc FSM.
// Word at address A appears on if_instruction one edge after imem_addr=A is accepted; stall freezes PC and memory output.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter addr_t       RESET_PC   = RESET_PC_DEF,
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  addr_t r_pc;
  addr_t r_pc_q;
  logic  r_v_q;

  addr_t w_pc_nxt;
  addr_t w_pc_q_nxt;
  logic  w_v_nxt;
  logic  w_fault;

  fetch_next_pc #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_next_pc (
    .clk               (clk),
    .reset             (reset),
    .i_stall           (bus.stall),
    .i_kill            (bus.kill),
    .i_redirect_valid  (bus.redirect_valid),
    .i_redirect_target (bus.redirect_target),
    .i_pc              (r_pc),
    .i_pc_q            (r_pc_q),
    .i_v_q             (r_v_q),
    .o_pc_nxt          (w_pc_nxt),
    .o_pc_q_nxt        (w_pc_q_nxt),
    .o_v_nxt           (w_v_nxt),
    .o_fault           (w_fault)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_pc_q <= 16'h0000;
      r_v_q  <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_pc_q <= w_pc_q_nxt;
      r_v_q  <= w_v_nxt;
    end
  end

  // A redirect must reach the memory even under a decode stall.
  assign bus.imem_addr      = r_pc;
  assign bus.imem_stall     = bus.stall & ~bus.redirect_valid;
  assign bus.if_instruction = bus.imem_instruction;
  assign bus.if_pc          = r_pc_q;
  assign bus.if_valid       = r_v_q;
  assign bus.fetch_fault    = w_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 1-cycle synchronous instruction memory model.
module tb_fetch_sequencer;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;

  logic [15:0] mem [256];
  logic [15:0] boot_words [4];

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC   (16'h0000),
    .IMEM_DEPTH (256)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    logic [7:0] idx;
    idx = a[7:0];
    if (a < 16'd256) return mem[idx];
    return 16'hDEAD;
  endfunction

  always @(posedge clk) begin
    if (!bus.imem_stall) bus.imem_instruction <= mem_rd(bus.imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] addr, input logic [15:0] pc,
                            input logic [15:0] instr, input logic v);
    chk16({tag, "_imem_addr"}, bus.imem_addr, addr);
    chk16({tag, "_if_pc"}, bus.if_pc, pc);
    chk1({tag, "_if_valid"}, bus.if_valid, v);
    if (v) chk16({tag, "_if_instr"}, bus.if_instruction, instr);
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    boot_words[0] = 16'h1111;
    boot_words[1] = 16'h2222;
    boot_words[2] = 16'h3333;
    boot_words[3] = 16'h4444;

    reset               = 1'b1;
    bus.stall           = 1'b0;
    bus.kill            = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 16'h0000;

    // Reset state
    tick();
    tick();
    chk16("rst_imem_addr", bus.imem_addr, 16'h0000);
    chk16("rst_if_pc", bus.if_pc, 16'h0000);
    chk1("rst_if_valid", bus.if_valid, 1'b0);
    chk1("rst_fault", bus.fetch_fault, 1'b0);

    // Release: one priming edge, then words 0..3 on consecutive cycles
    reset = 1'b0;
    tick();
    expect_out("prime", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("boot", 16'(i + 1), 16'(i), boot_words[i], 1'b1);
    end
    tick();
    expect_out("pre_stall", 16'h0005, 16'h0004, 16'hA004, 1'b1);

    // Three-cycle stall at imem_addr=5
    bus.stall = 1'b1;
    #1;
    chk1("stall_imem_stall", bus.imem_stall, 1'b1);
    repeat (3) begin
      tick();
      expect_out("stall_hold", 16'h0005, 16'h0004, 16'hA004, 1'b1);
    end
    bus.stall = 1'b0;
    tick();
    expect_out("resume", 16'h0006, 16'h0005, 16'hA005, 1'b1);

    // Kill squashes one word, PC still advances
    bus.kill = 1'b1;
    tick();
    expect_out("kill", 16'h0007, 16'h0006, 16'h0000, 1'b0);
    bus.kill = 1'b0;
    tick();
    expect_out("post_kill", 16'h0008, 16'h0007, 16'hA007, 1'b1);

    // Redirect to 0, run up to pc=2, then redirect to 10
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0000;
    tick();
    expect_out("redir0", 16'h0000, 16'h0008, 16'h0000, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    expect_out("run0", 16'h0001, 16'h0000, 16'h1111, 1'b1);
    tick();
    expect_out("run1", 16'h0002, 16'h0001, 16'h2222, 1'b1);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h000A;
    tick();
    expect_out("redirA_bubble", 16'h000A, 16'h0002, 16'h0000, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    expect_out("redirA_valid", 16'h000B, 16'h000A, 16'hA00A, 1'b1);

    // Redirect together with stall
    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0020;
    #1;
    chk1("redir_stall_imem_stall", bus.imem_stall, 1'b0);
    tick();
    expect_out("redir_stall", 16'h0020, 16'h000B, 16'h0000, 1'b0);
    bus.redirect_valid = 1'b0;
    #1;
    chk1("bubble_imem_stall", bus.imem_stall, 1'b1);
    tick();
    expect_out("bubble_hold", 16'h0020, 16'h000B, 16'h0000, 1'b0);
    bus.stall = 1'b0;
    tick();
    expect_out("after_hold", 16'h0021, 16'h0020, 16'hA020, 1'b1);

    // Run off the end of memory
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h00FE;
    tick();
    expect_out("redirFE", 16'h00FE, 16'h0021, 16'h0000, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    expect_out("w254", 16'h00FF, 16'h00FE, 16'hA0FE, 1'b1);
    tick();
    expect_out("w255", 16'h0100, 16'h00FF, 16'hA0FF, 1'b1);
    chk1("w255_fault", bus.fetch_fault, 1'b0);
    tick();
    chk1("fault_set", bus.fetch_fault, 1'b1);
    expect_out("fault1", 16'h0100, 16'h00FF, 16'h0000, 1'b0);
    tick();
    chk1("fault_held", bus.fetch_fault, 1'b1);
    expect_out("fault2", 16'h0100, 16'h00FF, 16'h0000, 1'b0);

    // Recover with in-range redirect
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0004;
    tick();
    chk1("clr_fault", bus.fetch_fault, 1'b0);
    expect_out("clr_bubble", 16'h0004, 16'h0100, 16'h0000, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    expect_out("clr_valid", 16'h0005, 16'h0004, 16'hA004, 1'b1);

    // Out-of-range redirect target faults on the following edge
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0300;
    tick();
    chk1("oor_redir_fault", bus.fetch_fault, 1'b0);
    expect_out("oor_redir", 16'h0300, 16'h0005, 16'h0000, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    chk1("oor_fault", bus.fetch_fault, 1'b1);
    expect_out("oor_fault", 16'h0300, 16'h0005, 16'h0000, 1'b0);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 16'h0400;
    tick();
    chk1("oor_refault", bus.fetch_fault, 1'b1);
    chk16("oor_refault_addr", bus.imem_addr, 16'h0400);
    chk1("oor_refault_valid", bus.if_valid, 1'b0);
    bus.redirect_valid = 1'b0;

    // Reset out of FAULT
    reset = 1'b1;
    tick();
    chk1("rst2_fault", bus.fetch_fault, 1'b0);
    chk16("rst2_if_pc", bus.if_pc, 16'h0000);
    expect_out("rst2", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    reset = 1'b0;
    tick();
    expect_out("reprime", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    tick();
    expect_out("reboot", 16'h0001, 16'h0000, 16'h1111, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
